// File: rtl/spi_reg_if.sv
// SPI strobe inputs and register-bus signals of the SPI register-access sequencer.
// The slave modport is the sequencer's view; master is the driving side.
interface spi_reg_if #(
  parameter int DATA_W = 16
);
  logic              spi_reset;
  logic              spi_read;
  logic              spi_write;
  logic              mosi_in;
  logic              miso;
  logic [6:0]        reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  spi_reset, spi_read, spi_write, mosi_in, reg_rdata,
    output miso, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );

  modport master (
    output spi_reset, spi_read, spi_write, mosi_in, reg_rdata,
    input  miso, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI-slave register-access sequencer: command byte {rnw, addr[6:0]} followed by
// DATA_W-bit data words streamed to/from the register bus, mode 0, MSB first.
//
// state | meaning
// IDLE  | after rst; all strobes ignored until spi_reset
// CMD   | shifting in the command byte
// WDATA | shifting in write words, one reg_wr per completed word
// RDATA | shifting out read words, reg_rd prefetches the next word
module spi_reg_ctrl #(
  parameter int DATA_W   = 16,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  spi_reg_if.slave     bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [6:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              rd_q;
  logic              rd_valid;
  logic              busy_q;
  logic              sample;
  logic              cmd_done;
  logic              word_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rx_next   = {rx_shift[DATA_W-2:0], bus.mosi_in};
    sample    = bus.spi_read && !bus.spi_reset && (state != IDLE);
    cmd_done  = sample && (state == CMD) && (bit_cnt == CNT_W'(7));
    word_done = sample && ((state == WDATA) || (state == RDATA)) &&
                (bit_cnt == CNT_W'(DATA_W - 1));
    if (bus.spi_reset)
      state_nx = CMD;
    else if (cmd_done)
      state_nx = rx_shift[6] ? RDATA : WDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_valid <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_valid <= rd_q;
      // Write address advances one cycle after its strobe, so reg_wr sees the old address.
      if (wr_q && AUTO_INC)
        addr_q <= addr_q + 7'd1;
      if (bus.spi_reset) begin
        bit_cnt  <= '0;
        tx_shift <= '0;
        rd_valid <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        if (sample) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end
        if (cmd_done) begin
          addr_q  <= rx_next[6:0];
          bit_cnt <= '0;
          rd_q    <= rx_shift[6];
        end
        if (word_done) begin
          bit_cnt <= '0;
          if (state == WDATA) begin
            wdata_q <= rx_next;
            wr_q    <= 1'b1;
          end else begin
            rd_q <= 1'b1;
            if (AUTO_INC)
              addr_q <= addr_q + 7'd1;
          end
        end
        // A word boundary falling edge must not shift: the prefetched word is already in place.
        if (state == RDATA) begin
          if (rd_valid)
            tx_shift <= bus.reg_rdata;
          else if (bus.spi_write && (bit_cnt != '0))
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.miso      = tx_shift[DATA_W-1];
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_rd    = rd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: one auto-increment instance and one fixed-address
// instance share the same SPI stimulus; bus activity is logged and checked per scenario.
module tb_spi_reg_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_if #(.DATA_W(16)) bus  ();
  spi_reg_if #(.DATA_W(16)) bus2 ();

  spi_reg_ctrl #(.DATA_W(16), .AUTO_INC(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_reg_ctrl #(.DATA_W(16), .AUTO_INC(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [15:0] mem [128];

  // Register file model: read data appears the cycle after reg_rd.
  always @(posedge clk) begin
    if (bus.reg_rd)  bus.reg_rdata  <= mem[bus.reg_addr];
    if (bus2.reg_rd) bus2.reg_rdata <= mem[bus2.reg_addr];
  end

  logic [6:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [6:0]  rd_addr_q [$];
  logic [6:0]  wr2_addr_q [$];
  int          collisions = 0;

  always @(negedge clk) begin
    if (bus.reg_wr) begin
      wr_addr_q.push_back(bus.reg_addr);
      wr_data_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_rd) rd_addr_q.push_back(bus.reg_addr);
    if (bus2.reg_wr) wr2_addr_q.push_back(bus2.reg_addr);
    if ((bus.reg_wr && bus.reg_rd) || (bus2.reg_wr && bus2.reg_rd)) collisions++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    wr2_addr_q.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    bus.spi_reset  = 1'b1;
    bus2.spi_reset = 1'b1;
    @(negedge clk);
    bus.spi_reset  = 1'b0;
    bus2.spi_reset = 1'b0;
    wait_clk(4);
  endtask

  // Mode 0 bit timing with ~12 clk sck period; miso captured at the sck-rising strobe.
  task automatic spi_xfer(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.mosi_in  = tx[i];
      bus2.mosi_in = tx[i];
      wait_clk(3);
      rx = {rx[30:0], bus.miso};
      bus.spi_read  = 1'b1;
      bus2.spi_read = 1'b1;
      @(negedge clk);
      bus.spi_read  = 1'b0;
      bus2.spi_read = 1'b0;
      wait_clk(5);
      bus.spi_write  = 1'b1;
      bus2.spi_write = 1'b1;
      @(negedge clk);
      bus.spi_write  = 1'b0;
      bus2.spi_write = 1'b0;
      wait_clk(2);
    end
  endtask

  logic [31:0] rx;

  initial begin
    bus.spi_reset  = 1'b0; bus.spi_read  = 1'b0; bus.spi_write  = 1'b0; bus.mosi_in  = 1'b0;
    bus2.spi_reset = 1'b0; bus2.spi_read = 1'b0; bus2.spi_write = 1'b0; bus2.mosi_in = 1'b0;
    bus.reg_rdata  = '0;
    bus2.reg_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    mem[3] = 16'hBEEF;
    mem[4] = 16'h1234;
    mem[5] = 16'h5A5A;

    wait_clk(3);
    check_val("rst_miso",  {31'd0, bus.miso},   32'h0);
    check_val("rst_addr",  {25'd0, bus.reg_addr}, 32'h0);
    check_val("rst_wdata", {16'd0, bus.reg_wdata}, 32'h0);
    check_val("rst_wr",    {31'd0, bus.reg_wr}, 32'h0);
    check_val("rst_rd",    {31'd0, bus.reg_rd}, 32'h0);
    check_val("rst_busy",  {31'd0, bus.busy},   32'h0);
    rst = 1'b0;
    wait_clk(3);

    // single write
    clear_logs();
    frame_start();
    check_val("w1_busy", {31'd0, bus.busy}, 32'h1);
    spi_xfer(8, 32'h05, rx);
    spi_xfer(16, 32'hA55A, rx);
    wait_clk(6);
    check_val("w1_count", wr_addr_q.size(), 32'd1);
    check_val("w1_addr",  {25'd0, wr_addr_q[0]}, 32'h05);
    check_val("w1_data",  {16'd0, wr_data_q[0]}, 32'hA55A);
    check_val("w1_nord",  rd_addr_q.size(), 32'd0);
    check_val("w1_next_addr", {25'd0, bus.reg_addr}, 32'h06);

    // burst write across the address wrap
    clear_logs();
    frame_start();
    spi_xfer(8, 32'h7F, rx);
    spi_xfer(16, 32'h1111, rx);
    spi_xfer(16, 32'h2222, rx);
    wait_clk(6);
    check_val("wrap_count", wr_addr_q.size(), 32'd2);
    check_val("wrap_addr0", {25'd0, wr_addr_q[0]}, 32'h7F);
    check_val("wrap_data0", {16'd0, wr_data_q[0]}, 32'h1111);
    check_val("wrap_addr1", {25'd0, wr_addr_q[1]}, 32'h00);
    check_val("wrap_data1", {16'd0, wr_data_q[1]}, 32'h2222);

    // two-word read with prefetch
    clear_logs();
    frame_start();
    spi_xfer(8, 32'h83, rx);
    spi_xfer(16, 32'h0, rx);
    check_val("rd_word0", rx, 32'hBEEF);
    spi_xfer(16, 32'h0, rx);
    check_val("rd_word1", rx, 32'h1234);
    wait_clk(6);
    check_val("rd_count", rd_addr_q.size(), 32'd3);
    check_val("rd_addr0", {25'd0, rd_addr_q[0]}, 32'h03);
    check_val("rd_addr1", {25'd0, rd_addr_q[1]}, 32'h04);
    check_val("rd_addr2", {25'd0, rd_addr_q[2]}, 32'h05);
    check_val("rd_nowr",  wr_addr_q.size(), 32'd0);

    // fixed-address burst on the AUTO_INC=0 instance
    clear_logs();
    frame_start();
    spi_xfer(8, 32'h10, rx);
    spi_xfer(16, 32'hAAAA, rx);
    spi_xfer(16, 32'h5555, rx);
    spi_xfer(16, 32'h0F0F, rx);
    wait_clk(6);
    check_val("fix_count", wr2_addr_q.size(), 32'd3);
    check_val("fix_addr0", {25'd0, wr2_addr_q[0]}, 32'h10);
    check_val("fix_addr1", {25'd0, wr2_addr_q[1]}, 32'h10);
    check_val("fix_addr2", {25'd0, wr2_addr_q[2]}, 32'h10);
    check_val("inc_addr2", {25'd0, wr_addr_q[2]}, 32'h12);

    // abort a partial write word
    clear_logs();
    frame_start();
    spi_xfer(8, 32'h01, rx);
    spi_xfer(5, 32'h1F, rx);
    frame_start();
    check_val("abort_nowr", wr_addr_q.size(), 32'd0);
    spi_xfer(8, 32'h02, rx);
    spi_xfer(16, 32'h00FF, rx);
    wait_clk(6);
    check_val("abort_count", wr_addr_q.size(), 32'd1);
    check_val("abort_addr",  {25'd0, wr_addr_q[0]}, 32'h02);
    check_val("abort_data",  {16'd0, wr_data_q[0]}, 32'h00FF);

    // rst in the middle of a read word
    frame_start();
    spi_xfer(8, 32'h83, rx);
    spi_xfer(4, 32'h0, rx);
    check_val("mid_miso", {31'd0, bus.miso}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("arst_miso", {31'd0, bus.miso},     32'h0);
    check_val("arst_addr", {25'd0, bus.reg_addr}, 32'h0);
    check_val("arst_busy", {31'd0, bus.busy},     32'h0);
    check_val("arst_wdata", {16'd0, bus.reg_wdata}, 32'h0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    clear_logs();
    spi_xfer(8, 32'hFF, rx);
    spi_xfer(16, 32'hFFFF, rx);
    wait_clk(6);
    check_val("idle_nowr", wr_addr_q.size(), 32'd0);
    check_val("idle_nord", rd_addr_q.size(), 32'd0);
    check_val("idle_addr", {25'd0, bus.reg_addr}, 32'h0);
    check_val("idle_busy", {31'd0, bus.busy},     32'h0);
    frame_start();
    spi_xfer(8, 32'h20, rx);
    spi_xfer(16, 32'hC3C3, rx);
    wait_clk(6);
    check_val("post_count", wr_addr_q.size(), 32'd1);
    check_val("post_addr",  {25'd0, wr_addr_q[0]}, 32'h20);
    check_val("post_data",  {16'd0, wr_data_q[0]}, 32'hC3C3);

    check_val("no_wr_rd_overlap", collisions, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
